// File: rtl/stream_fifo_rr_arbiter.sv
// Round-robin burst arbiter that shares one StreamingFIFO write port among NUM_IN
// AXI-Stream requesters, starting a burst only when the FIFO can absorb all of it.
module stream_fifo_rr_arbiter #(
    parameter int NUM_IN     = 4,
    parameter int WIDTH      = 8,
    parameter int BURST      = 16,
    parameter int FIFO_DEPTH = 16384,
    parameter int COUNT_W    = 14
) (
    input  logic                      ap_clk,
    input  logic                      reset,
    input  logic [NUM_IN*WIDTH-1:0]   s_tdata,
    input  logic [NUM_IN-1:0]         s_tvalid,
    input  logic [NUM_IN-1:0]         s_tlast,
    output logic [NUM_IN-1:0]         s_tready,
    output logic [WIDTH-1:0]          m_tdata,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    input  logic [COUNT_W-1:0]        fifo_count,
    output logic [NUM_IN-1:0]         grant,
    output logic                      busy
);

    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;

    localparam logic [COUNT_W:0]   DEPTH_W   = (COUNT_W + 1)'(FIFO_DEPTH);
    localparam logic [COUNT_W:0]   BURST_W   = (COUNT_W + 1)'(BURST);
    localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(BURST - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_IN - 1);
    localparam logic [IDX_W:0]     NUM_W     = (IDX_W + 1)'(NUM_IN);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t              state_reg;
    logic [NUM_IN-1:0]   grant_reg;
    logic [IDX_W-1:0]    last_reg;
    logic [CNT_W-1:0]    beat_cnt_reg;

    logic [WIDTH-1:0]    lane_data [NUM_IN];
    logic                xfer;
    logic                sel_valid;
    logic                sel_last;
    logic                beat;
    logic                burst_done;

    logic [COUNT_W:0]    count_ext;
    logic [COUNT_W:0]    free;
    logic                room;

    logic [IDX_W:0]      cand_sum;
    logic [IDX_W-1:0]    cand_idx;
    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;
    logic [NUM_IN-1:0]   pick_onehot;

    assign xfer = (state_reg == XFER);

    // Per-lane data unpacking and ready steering: only the granted lane sees m_tready.
    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_lane
            assign lane_data[gi] = s_tdata[gi*WIDTH +: WIDTH];
            assign s_tready[gi]  = xfer & grant_reg[gi] & m_tready;
        end
    endgenerate

    assign sel_valid = s_tvalid[last_reg];
    assign sel_last  = s_tlast[last_reg];

    assign m_tvalid  = xfer & sel_valid;
    assign m_tdata   = xfer ? lane_data[last_reg] : '0;

    assign beat       = m_tvalid & m_tready;
    assign burst_done = beat & ((beat_cnt_reg == LAST_BEAT) | sel_last);

    // Free space saturates at zero if the reported occupancy ever exceeds the depth.
    assign count_ext = {1'b0, fifo_count};
    assign free      = (count_ext > DEPTH_W) ? '0 : (DEPTH_W - count_ext);
    assign room      = (free >= BURST_W);

    // Scan from the lane after the last grant, wrapping, and take the first valid one.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_sum   = '0;
        cand_idx   = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            cand_sum = {1'b0, last_reg} + (IDX_W + 1)'(k);
            if (cand_sum >= NUM_W) begin
                cand_sum = cand_sum - NUM_W;
            end
            cand_idx = cand_sum[IDX_W-1:0];
            if (!pick_found && s_tvalid[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    assign pick_onehot = NUM_IN'(1) << pick_idx;

    always_ff @(posedge ap_clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            last_reg     <= LAST_IDX;
            beat_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_found && room) begin
                        state_reg    <= XFER;
                        grant_reg    <= pick_onehot;
                        last_reg     <= pick_idx;
                        beat_cnt_reg <= '0;
                    end
                end
                XFER: begin
                    // A missing valid or ready simply holds the burst; no timeout.
                    if (burst_done) begin
                        state_reg    <= IDLE;
                        grant_reg    <= '0;
                        beat_cnt_reg <= '0;
                    end else if (beat) begin
                        beat_cnt_reg <= beat_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    grant_reg    <= '0;
                    beat_cnt_reg <= '0;
                end
            endcase
        end
    end

    assign grant = grant_reg;
    assign busy  = xfer;

endmodule

// File: tb/tb_stream_fifo_rr_arbiter.sv
// Directed scoreboard bench: stimulus queues expected FIFO-side beats, a monitor
// pops and compares them whenever the arbiter hands a beat to the FIFO.
module tb_stream_fifo_rr_arbiter;

    localparam int NUM_IN     = 4;
    localparam int WIDTH      = 8;
    localparam int BURST      = 16;
    localparam int FIFO_DEPTH = 16384;
    localparam int COUNT_W    = 14;

    logic                    ap_clk = 1'b0;
    logic                    reset  = 1'b1;
    logic [NUM_IN*WIDTH-1:0] s_tdata  = '0;
    logic [NUM_IN-1:0]       s_tvalid = '0;
    logic [NUM_IN-1:0]       s_tlast  = '0;
    logic [NUM_IN-1:0]       s_tready;
    logic [WIDTH-1:0]        m_tdata;
    logic                    m_tvalid;
    logic                    m_tready = 1'b0;
    logic [COUNT_W-1:0]      fifo_count = '0;
    logic [NUM_IN-1:0]       grant;
    logic                    busy;

    stream_fifo_rr_arbiter #(
        .NUM_IN     (NUM_IN),
        .WIDTH      (WIDTH),
        .BURST      (BURST),
        .FIFO_DEPTH (FIFO_DEPTH),
        .COUNT_W    (COUNT_W)
    ) dut (
        .ap_clk     (ap_clk),
        .reset      (reset),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .fifo_count (fifo_count),
        .grant      (grant),
        .busy       (busy)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        int         lane;
        logic [7:0] data;
        int         gap;
    } beat_t;

    beat_t exp_q[$];

    int checks = 0;
    int passed = 0;

    int          seq      [NUM_IN];
    int          last_seq [NUM_IN];
    int          exp_seq  [NUM_IN];
    logic [NUM_IN-1:0] vld_en = '0;

    int   mon_cyc = 0;
    int   mon_last_cyc = -100;
    logic mon_prev_busy = 1'b0;
    beat_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Requester model: lane i sends bytes i*64 + sequence number.
    task automatic drive();
        for (int i = 0; i < NUM_IN; i++) begin
            s_tdata[i*WIDTH +: WIDTH] = 8'(i * 64 + (seq[i] % 64));
            s_tvalid[i] = vld_en[i];
            s_tlast[i]  = (seq[i] == last_seq[i]);
        end
    endtask

    task automatic step();
        logic [NUM_IN-1:0] fire;
        @(negedge ap_clk);
        fire = s_tvalid & s_tready;
        @(posedge ap_clk);
        #1;
        for (int i = 0; i < NUM_IN; i++) if (fire[i]) seq[i]++;
        drive();
    endtask

    task automatic push_burst(input int lane, input int n, input int first_gap, input int inner_gap);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.lane = lane;
            b.data = 8'(lane * 64 + (exp_seq[lane] % 64));
            b.gap  = (k == 0) ? first_gap : inner_gap;
            exp_q.push_back(b);
            exp_seq[lane]++;
        end
    endtask

    task automatic wait_q(input int target, input int limit, input string name);
        int n;
        n = 0;
        while (exp_q.size() > target && n < limit) begin
            step();
            n++;
        end
        check(name, exp_q.size(), target);
    endtask

    // Monitor: every beat handed to the FIFO is matched against the scoreboard.
    initial begin
        forever begin
            @(negedge ap_clk);
            mon_cyc++;
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_beat: got data %0h grant %0b, expected no beat", m_tdata, grant);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat_data", 32'(m_tdata), 32'(mon_e.data));
                    check("beat_grant", 32'(grant), 32'(1) << mon_e.lane);
                    if (mon_e.gap >= 0) check("beat_gap", 32'(mon_cyc - mon_last_cyc - 1), 32'(mon_e.gap));
                end
                mon_last_cyc = mon_cyc;
            end
            if (mon_prev_busy && !busy) begin
                check("end_grant", 32'(grant), 32'(0));
                check("end_s_tready", 32'(s_tready), 32'(0));
                check("end_m_tvalid", 32'(m_tvalid), 32'(0));
            end
            mon_prev_busy = busy;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < NUM_IN; i++) begin
            seq[i] = 0;
            last_seq[i] = -1;
            exp_seq[i] = 0;
        end
        drive();

        // Reset state
        reset = 1'b1;
        repeat (3) step();
        check("rst_grant", 32'(grant), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_s_tready", 32'(s_tready), 32'(0));
        check("rst_m_tvalid", 32'(m_tvalid), 32'(0));
        check("rst_m_tdata", 32'(m_tdata), 32'(0));
        reset = 1'b0;
        step();

        // All four lanes valid: order 0,1,2,3,0 with one idle cycle between bursts
        m_tready = 1'b1;
        vld_en = 4'b1111;
        drive();
        push_burst(0, 16, -1, 0);
        push_burst(1, 16, 1, 0);
        push_burst(2, 16, 1, 0);
        push_burst(3, 16, 1, 0);
        push_burst(0, 16, 1, 0);
        wait_q(0, 200, "t1_drain");
        check("t1_busy_end", 32'(busy), 32'(0));
        vld_en = '0;
        drive();
        repeat (2) step();

        // Lane 2 alone, tlast on its 5th beat, then a full burst after one idle cycle
        last_seq[2] = seq[2] + 4;
        vld_en = 4'b0100;
        drive();
        push_burst(2, 5, -1, 0);
        push_burst(2, 16, 1, 0);
        wait_q(0, 100, "t2_drain");
        check("t2_busy_end", 32'(busy), 32'(0));
        vld_en = '0;
        last_seq[2] = -1;
        drive();
        repeat (2) step();

        // Not enough room: free=14 and free=15 block, free=16 grants
        vld_en = 4'b0010;
        fifo_count = 14'd16370;
        drive();
        repeat (4) step();
        check("t3_free14_grant", 32'(grant), 32'(0));
        check("t3_free14_ready", 32'(s_tready), 32'(0));
        check("t3_free14_busy", 32'(busy), 32'(0));
        fifo_count = 14'd16369;
        repeat (3) step();
        check("t3_free15_grant", 32'(grant), 32'(0));
        push_burst(1, 16, -1, 0);
        fifo_count = 14'd16368;
        step();
        check("t3_free16_grant", 32'(grant), 32'(4'b0010));
        wait_q(0, 100, "t3_drain");
        check("t3_busy_end", 32'(busy), 32'(0));
        vld_en = '0;
        fifo_count = '0;
        drive();
        repeat (2) step();

        // m_tready pattern 1,0,0,1: still exactly 16 accepted beats, order kept
        vld_en = 4'b1000;
        drive();
        push_burst(3, 16, -1, -1);
        begin
            int n;
            logic [3:0] pat;
            pat = 4'b1001;
            n = 0;
            while (exp_q.size() > 0 && n < 400) begin
                m_tready = pat[n % 4];
                step();
                n++;
            end
            check("t4_drain", exp_q.size(), 0);
        end
        check("t4_busy_end", 32'(busy), 32'(0));
        check("t4_grant_end", 32'(grant), 32'(0));
        m_tready = 1'b1;
        vld_en = '0;
        drive();
        repeat (2) step();

        // Reset during the 7th beat of lane 3's burst
        vld_en = 4'b1000;
        drive();
        push_burst(3, 7, -1, 0);
        wait_q(1, 100, "t5_pre_reset");
        reset = 1'b1;
        step();
        check("t5_rst_grant", 32'(grant), 32'(0));
        check("t5_rst_busy", 32'(busy), 32'(0));
        check("t5_rst_ready", 32'(s_tready), 32'(0));
        check("t5_rst_q", exp_q.size(), 0);
        reset = 1'b0;
        vld_en = 4'b1001;
        drive();
        push_burst(0, 16, -1, 0);
        push_burst(3, 16, 1, 0);
        wait_q(0, 100, "t5_drain");
        check("t5_busy_end", 32'(busy), 32'(0));
        vld_en = '0;
        drive();
        repeat (2) step();

        // Near-full FIFO: free=1, nothing may be granted
        fifo_count = 14'd16383;
        vld_en = 4'b1111;
        drive();
        for (int k = 0; k < 4; k++) begin
            repeat (5) step();
            check("t6_grant", 32'(grant), 32'(0));
            check("t6_ready", 32'(s_tready), 32'(0));
        end
        vld_en = '0;
        fifo_count = '0;
        drive();
        repeat (3) step();
        check("final_q", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
